// File: rtl/id_pipe.sv
// Instruction decode: immediate sign-extension, register file with EX/MEM/WB forwarding, load-use detection, ID/EX register.
// Latency: one cycle from an instruction accepted on an edge to the ex_* outputs after that edge.
// Backpressure: ex_ready=0 holds ID/EX and drops id_ready; a load-use hazard drops id_ready and injects a bubble.
module id_pipe #(
  parameter  int XLEN = 32,
  parameter  int NREG = 32,
  localparam int RW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  // IF/ID side
  input  logic            if_valid,
  input  logic [31:0]     if_inst,
  input  logic [XLEN-1:0] if_pc,
  input  logic [XLEN-1:0] if_pc4,
  input  logic [2:0]      sext_op,
  input  logic            use_rs1,
  input  logic            use_rs2,
  input  logic            dec_rf_we,
  input  logic [1:0]      dec_wd_sel,
  input  logic            dec_is_load,
  output logic            id_ready,
  input  logic            flush,
  // forwarding sources
  input  logic            ex_fwd_we,
  input  logic            ex_fwd_is_load,
  input  logic [RW-1:0]   ex_fwd_wr,
  input  logic [XLEN-1:0] ex_fwd_wd,
  input  logic            mem_fwd_we,
  input  logic [RW-1:0]   mem_fwd_wr,
  input  logic [XLEN-1:0] mem_fwd_wd,
  input  logic            wb_we,
  input  logic [RW-1:0]   wb_wr,
  input  logic [XLEN-1:0] wb_wd,
  // ID/EX side
  input  logic            ex_ready,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_rd1,
  output logic [XLEN-1:0] ex_rd2,
  output logic [XLEN-1:0] ex_ext,
  output logic [RW-1:0]   ex_wr,
  output logic            ex_rf_we,
  output logic            ex_is_load,
  output logic [1:0]      ex_wd_sel,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_pc4
);

  typedef struct packed {
    logic            valid;
    logic            rf_we;
    logic            is_load;
    logic [1:0]      wd_sel;
    logic [RW-1:0]   wr;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] ext;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
  } idex_t;

  logic [RW-1:0]   rs1;
  logic [RW-1:0]   rs2;
  logic [RW-1:0]   rd;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rf [NREG];
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic            hazard;
  idex_t           dec;
  idex_t           idex;
  logic            unused_opcode;

  // Opcode bits are decoded upstream; only register fields and immediates matter here.
  assign unused_opcode = ^if_inst[6:0];

  assign rs1 = if_inst[15 +: RW];
  assign rs2 = if_inst[20 +: RW];
  assign rd  = if_inst[7 +: RW];

  // Assemble the 32-bit immediate for the selected format; unknown formats yield zero.
  always_comb begin
    imm32 = '0;
    case (sext_op)
      3'd1:    imm32 = {{20{if_inst[31]}}, if_inst[31:20]};
      3'd2:    imm32 = {{20{if_inst[31]}}, if_inst[31:25], if_inst[11:7]};
      3'd3:    imm32 = {{19{if_inst[31]}}, if_inst[31], if_inst[7], if_inst[30:25], if_inst[11:8], 1'b0};
      3'd4:    imm32 = {if_inst[31:12], 12'b0};
      3'd5:    imm32 = {{11{if_inst[31]}}, if_inst[31], if_inst[19:12], if_inst[20], if_inst[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // Every format is already sign-filled at 32 bits, so widening to XLEN is a signed cast.
  assign imm = XLEN'($signed(imm32));

  // Architectural register file; x0 is never written so it stays zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wb_we && wb_wr != '0) begin
      rf[wb_wr] <= wb_wd;
    end
  end

  // Youngest producer wins; the WB match covers the write landing on this same edge.
  function automatic logic [XLEN-1:0] pick_operand(input logic [RW-1:0] rs, input logic [XLEN-1:0] stored);
    if (rs == '0)                            return '0;
    else if (ex_fwd_we  && ex_fwd_wr  == rs) return ex_fwd_wd;
    else if (mem_fwd_we && mem_fwd_wr == rs) return mem_fwd_wd;
    else if (wb_we      && wb_wr      == rs) return wb_wd;
    else                                     return stored;
  endfunction

  // Operand selection for both sources.
  always_comb begin
    op1 = pick_operand(rs1, rf[rs1]);
    op2 = pick_operand(rs2, rf[rs2]);
  end

  // A load in EX cannot forward yet; hold the dependent instruction one cycle until it reaches MEM.
  assign hazard = if_valid && ex_fwd_we && ex_fwd_is_load && (ex_fwd_wr != '0) &&
                  ((use_rs1 && ex_fwd_wr == rs1) || (use_rs2 && ex_fwd_wr == rs2));

  assign id_ready = ex_ready && !hazard;

  // Decoded contents that would enter ID/EX on a normal advance.
  always_comb begin
    dec         = '0;
    dec.valid   = if_valid;
    dec.rf_we   = dec_rf_we && if_valid;
    dec.is_load = dec_is_load && if_valid;
    dec.wd_sel  = dec_wd_sel;
    dec.wr      = rd;
    dec.rd1     = op1;
    dec.rd2     = op2;
    dec.ext     = imm;
    dec.pc      = if_pc;
    dec.pc4     = if_pc4;
  end

  // ID/EX register: flush beats hold, hold beats bubble, bubble beats advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex <= '0;
    end else if (flush) begin
      idex.valid   <= 1'b0;
      idex.rf_we   <= 1'b0;
      idex.is_load <= 1'b0;
    end else if (!ex_ready) begin
      idex <= idex;
    end else if (hazard) begin
      idex.valid   <= 1'b0;
      idex.rf_we   <= 1'b0;
      idex.is_load <= 1'b0;
    end else begin
      idex <= dec;
    end
  end

  assign ex_valid   = idex.valid;
  assign ex_rf_we   = idex.rf_we;
  assign ex_is_load = idex.is_load;
  assign ex_wd_sel  = idex.wd_sel;
  assign ex_wr      = idex.wr;
  assign ex_rd1     = idex.rd1;
  assign ex_rd2     = idex.rd2;
  assign ex_ext     = idex.ext;
  assign ex_pc      = idex.pc;
  assign ex_pc4     = idex.pc4;

endmodule

// File: tb/tb_id_pipe.sv
// Bench for id_pipe: randomized and directed stimulus against a behavioural decode-stage model.
// Latency: the model predicts ID/EX contents one edge after the inputs it sees.
// Backpressure: flush/hold/bubble/advance outcomes are predicted per cycle from ex_ready, flush and the hazard rule.
module tb_id_pipe;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int RW   = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            if_valid, use_rs1, use_rs2, dec_rf_we, dec_is_load, flush;
  logic [31:0]     if_inst;
  logic [XLEN-1:0] if_pc, if_pc4;
  logic [2:0]      sext_op;
  logic [1:0]      dec_wd_sel;
  logic            ex_fwd_we, ex_fwd_is_load, mem_fwd_we, wb_we, ex_ready;
  logic [RW-1:0]   ex_fwd_wr, mem_fwd_wr, wb_wr;
  logic [XLEN-1:0] ex_fwd_wd, mem_fwd_wd, wb_wd;
  logic            id_ready, ex_valid, ex_rf_we, ex_is_load;
  logic [XLEN-1:0] ex_rd1, ex_rd2, ex_ext, ex_pc, ex_pc4;
  logic [RW-1:0]   ex_wr;
  logic [1:0]      ex_wd_sel;

  always #5 clk = ~clk;

  id_pipe #(.XLEN(XLEN), .NREG(NREG)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .if_pc4(if_pc4),
    .sext_op(sext_op), .use_rs1(use_rs1), .use_rs2(use_rs2),
    .dec_rf_we(dec_rf_we), .dec_wd_sel(dec_wd_sel), .dec_is_load(dec_is_load),
    .id_ready(id_ready), .flush(flush),
    .ex_fwd_we(ex_fwd_we), .ex_fwd_is_load(ex_fwd_is_load), .ex_fwd_wr(ex_fwd_wr), .ex_fwd_wd(ex_fwd_wd),
    .mem_fwd_we(mem_fwd_we), .mem_fwd_wr(mem_fwd_wr), .mem_fwd_wd(mem_fwd_wd),
    .wb_we(wb_we), .wb_wr(wb_wr), .wb_wd(wb_wd),
    .ex_ready(ex_ready), .ex_valid(ex_valid),
    .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_ext(ex_ext), .ex_wr(ex_wr),
    .ex_rf_we(ex_rf_we), .ex_is_load(ex_is_load), .ex_wd_sel(ex_wd_sel),
    .ex_pc(ex_pc), .ex_pc4(ex_pc4)
  );

  int errors = 0;
  int checks = 0;

  // Model state: architectural registers and the expected ID/EX contents.
  logic [31:0] reg_m [32];
  logic        e_valid, e_rf_we, e_is_load;
  logic [1:0]  e_wd_sel;
  logic [4:0]  e_wr;
  logic [31:0] e_rd1, e_rd2, e_ext, e_pc, e_pc4;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] imm_model(input logic [31:0] inst, input logic [2:0] op);
    logic [31:0] sx;
    sx = inst[31] ? 32'hFFFF_FFFF : 32'h0;
    case (op)
      3'd1:    return (sx << 12) | (inst >> 20);
      3'd2:    return (sx << 12) | ((inst >> 25) << 5) | ((inst >> 7) & 32'h1F);
      3'd3:    return (sx << 12) | (((inst >> 7) & 32'h1) << 11) | (((inst >> 25) & 32'h3F) << 5) | (((inst >> 8) & 32'hF) << 1);
      3'd4:    return inst & 32'hFFFF_F000;
      3'd5:    return (sx << 20) | (inst & 32'h000F_F000) | (((inst >> 20) & 32'h1) << 11) | (((inst >> 21) & 32'h3FF) << 1);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] operand_model(input logic [4:0] rs);
    if (rs == 0)                            return 32'h0;
    if (ex_fwd_we  && ex_fwd_wr  == rs)     return ex_fwd_wd;
    if (mem_fwd_we && mem_fwd_wr == rs)     return mem_fwd_wd;
    if (wb_we      && wb_wr      == rs)     return wb_wd;
    return reg_m[rs];
  endfunction

  function automatic logic [31:0] mk_inst(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    return {7'h00, rs2, rs1, 3'b000, rd, 7'h33};
  endfunction

  // One clock of stimulus: predict from the applied inputs, cross the edge, compare.
  task automatic cycle();
    logic [4:0]  rs1, rs2;
    logic        haz;
    logic [31:0] op1, op2;
    #1;
    rs1 = if_inst[19:15];
    rs2 = if_inst[24:20];
    haz = if_valid && ex_fwd_we && ex_fwd_is_load && (ex_fwd_wr != 0) &&
          ((use_rs1 && ex_fwd_wr == rs1) || (use_rs2 && ex_fwd_wr == rs2));
    chk("id_ready", {31'b0, id_ready}, {31'b0, ex_ready && !haz});
    op1 = operand_model(rs1);
    op2 = operand_model(rs2);
    if (wb_we && wb_wr != 0) reg_m[wb_wr] = wb_wd;
    @(posedge clk);
    #1;
    if (flush || (ex_ready && haz)) begin
      e_valid = 1'b0; e_rf_we = 1'b0; e_is_load = 1'b0;
    end else if (ex_ready) begin
      e_valid = if_valid; e_rf_we = dec_rf_we && if_valid; e_is_load = dec_is_load && if_valid;
      e_wd_sel = dec_wd_sel; e_wr = if_inst[11:7];
      e_rd1 = op1; e_rd2 = op2; e_ext = imm_model(if_inst, sext_op);
      e_pc = if_pc; e_pc4 = if_pc4;
    end
    chk("ex_valid",   {31'b0, ex_valid},   {31'b0, e_valid});
    chk("ex_rf_we",   {31'b0, ex_rf_we},   {31'b0, e_rf_we});
    chk("ex_is_load", {31'b0, ex_is_load}, {31'b0, e_is_load});
    if (e_valid) begin
      chk("ex_rd1", ex_rd1, e_rd1);
      chk("ex_rd2", ex_rd2, e_rd2);
      chk("ex_ext", ex_ext, e_ext);
      chk("ex_wr", {27'b0, ex_wr}, {27'b0, e_wr});
      chk("ex_wd_sel", {30'b0, ex_wd_sel}, {30'b0, e_wd_sel});
      chk("ex_pc", ex_pc, e_pc);
      chk("ex_pc4", ex_pc4, e_pc4);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"},   {31'b0, ex_valid},   32'h0);
    chk({tag, "_rf_we"},   {31'b0, ex_rf_we},   32'h0);
    chk({tag, "_is_load"}, {31'b0, ex_is_load}, 32'h0);
    chk({tag, "_rd1"}, ex_rd1, 32'h0);
    chk({tag, "_rd2"}, ex_rd2, 32'h0);
    chk({tag, "_ext"}, ex_ext, 32'h0);
    chk({tag, "_wr"}, {27'b0, ex_wr}, 32'h0);
    chk({tag, "_wd_sel"}, {30'b0, ex_wd_sel}, 32'h0);
    chk({tag, "_pc"}, ex_pc, 32'h0);
    chk({tag, "_pc4"}, ex_pc4, 32'h0);
  endtask

  // Assert reset asynchronously, confirm it clears at once and across an edge, then release.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk_all_zero("rst_now");
    @(posedge clk);
    #1;
    chk_all_zero("rst_edge");
    rst = 1'b0;
    for (int i = 0; i < 32; i++) reg_m[i] = 32'h0;
    e_valid = 0; e_rf_we = 0; e_is_load = 0; e_wd_sel = 0; e_wr = 0;
    e_rd1 = 0; e_rd2 = 0; e_ext = 0; e_pc = 0; e_pc4 = 0;
  endtask

  task automatic quiet();
    if_valid = 1; ex_ready = 1; flush = 0;
    use_rs1 = 1; use_rs2 = 1; dec_rf_we = 1; dec_is_load = 0; dec_wd_sel = 2'd1;
    sext_op = 3'd1;
    ex_fwd_we = 0; ex_fwd_is_load = 0; ex_fwd_wr = 0; ex_fwd_wd = 32'h0;
    mem_fwd_we = 0; mem_fwd_wr = 0; mem_fwd_wd = 32'h0;
    wb_we = 0; wb_wr = 0; wb_wd = 32'h0;
    if_pc = 32'h0000_1000; if_pc4 = 32'h0000_1004;
  endtask

  task automatic rand_inputs();
    if_valid = ($urandom % 4) != 0;
    if_inst = $urandom;
    if_inst[19:15] = 5'($urandom_range(0, 7));
    if_inst[24:20] = 5'($urandom_range(0, 7));
    sext_op = 3'($urandom_range(0, 7));
    use_rs1 = 1'($urandom); use_rs2 = 1'($urandom);
    dec_rf_we = 1'($urandom); dec_is_load = 1'($urandom); dec_wd_sel = 2'($urandom);
    flush = ($urandom % 10) == 0;
    ex_ready = ($urandom % 5) != 0;
    ex_fwd_we = 1'($urandom); ex_fwd_is_load = ($urandom % 3) == 0;
    ex_fwd_wr = 5'($urandom_range(0, 7)); ex_fwd_wd = $urandom;
    mem_fwd_we = 1'($urandom); mem_fwd_wr = 5'($urandom_range(0, 7)); mem_fwd_wd = $urandom;
    wb_we = 1'($urandom); wb_wr = 5'($urandom_range(0, 7)); wb_wd = $urandom;
    if_pc = $urandom; if_pc4 = if_pc + 32'd4;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    rand_inputs();
    #1;
    do_reset();

    // Every register reads zero after reset.
    quiet();
    for (int r = 1; r < 32; r++) begin
      if_inst = mk_inst(5'(r), 5'(r), 5'd1);
      cycle();
      chk("rf_clear", ex_rd1, 32'h0);
    end

    // WB write, then addi x6,x5,-1 reads it from the register file.
    quiet();
    if_valid = 0; wb_we = 1; wb_wr = 5'd5; wb_wd = 32'h1234_5678;
    cycle();
    quiet();
    if_inst = 32'hFFF2_8313;
    cycle();
    chk("addi_rd1", ex_rd1, 32'h1234_5678);
    chk("addi_ext", ex_ext, 32'hFFFF_FFFF);
    chk("addi_wr", {27'b0, ex_wr}, 32'd6);

    // Forwarding priority on x7, then on x0.
    quiet();
    if_inst = mk_inst(5'd7, 5'd0, 5'd1);
    ex_fwd_we = 1;  ex_fwd_wr = 5'd7;  ex_fwd_wd = 32'hA;
    mem_fwd_we = 1; mem_fwd_wr = 5'd7; mem_fwd_wd = 32'hB;
    wb_we = 1;      wb_wr = 5'd7;      wb_wd = 32'hC;
    cycle(); chk("fwd_ex", ex_rd1, 32'hA);
    ex_fwd_we = 0;
    cycle(); chk("fwd_mem", ex_rd1, 32'hB);
    mem_fwd_we = 0;
    cycle(); chk("fwd_wb", ex_rd1, 32'hC);
    if_inst = mk_inst(5'd0, 5'd0, 5'd1);
    ex_fwd_we = 1; ex_fwd_wr = 5'd0; mem_fwd_we = 1; mem_fwd_wr = 5'd0; wb_wr = 5'd0;
    cycle(); chk("fwd_x0", ex_rd1, 32'h0);

    // Load-use on x3: one bubble, then the MEM forward supplies the value.
    quiet();
    if_inst = 32'h0011_8233;
    ex_fwd_we = 1; ex_fwd_is_load = 1; ex_fwd_wr = 5'd3; ex_fwd_wd = 32'h0BAD_0BAD;
    #1; chk("lu_stall_ready", {31'b0, id_ready}, 32'h0);
    cycle(); chk("lu_bubble_valid", {31'b0, ex_valid}, 32'h0);
    ex_fwd_we = 0; ex_fwd_is_load = 0;
    mem_fwd_we = 1; mem_fwd_wr = 5'd3; mem_fwd_wd = 32'hDEAD_BEEF;
    #1; chk("lu_resume_ready", {31'b0, id_ready}, 32'h1);
    cycle();
    chk("lu_valid", {31'b0, ex_valid}, 32'h1);
    chk("lu_rd1", ex_rd1, 32'hDEAD_BEEF);
    chk("lu_wr", {27'b0, ex_wr}, 32'd4);

    // Backpressure for three cycles with a flush in the second.
    quiet();
    if_inst = 32'h0050_0113; if_pc = 32'h100; if_pc4 = 32'h104;
    cycle(); chk("bp_load_ext", ex_ext, 32'd5);
    ex_ready = 0; if_inst = 32'hFFF2_8313; if_pc = 32'h104; if_pc4 = 32'h108;
    #1; chk("bp_ready", {31'b0, id_ready}, 32'h0);
    cycle();
    chk("bp_hold_ext", ex_ext, 32'd5);
    chk("bp_hold_pc", ex_pc, 32'h100);
    chk("bp_hold_valid", {31'b0, ex_valid}, 32'h1);
    flush = 1;
    cycle(); chk("bp_flush_valid", {31'b0, ex_valid}, 32'h0);
    flush = 0;
    cycle(); chk("bp_after_valid", {31'b0, ex_valid}, 32'h0);
    ex_ready = 1;
    cycle(); chk("bp_resume_ext", ex_ext, 32'hFFFF_FFFF);

    // Immediate format pins.
    quiet();
    if_inst = 32'hFE00_0EE3; sext_op = 3'd3;
    cycle(); chk("imm_b", ex_ext, 32'hFFFF_FFFC);
    if_inst = 32'h8000_00B7; sext_op = 3'd4;
    cycle(); chk("imm_u", ex_ext, 32'h8000_0000);

    // Reset during a load-use stall clears the pipe register and the register file.
    quiet();
    if_valid = 0; wb_we = 1; wb_wr = 5'd9; wb_wd = 32'h55;
    cycle();
    quiet();
    if_inst = mk_inst(5'd9, 5'd0, 5'd2);
    cycle(); chk("pre_rst_rd1", ex_rd1, 32'h55);
    ex_fwd_we = 1; ex_fwd_is_load = 1; ex_fwd_wr = 5'd9;
    #1; chk("midstall_ready", {31'b0, id_ready}, 32'h0);
    do_reset();
    quiet();
    if_inst = mk_inst(5'd9, 5'd0, 5'd2);
    cycle(); chk("post_rst_rd1", ex_rd1, 32'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      rand_inputs();
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
